retire_map: RTL and testbench
=============================

// Module: retire_map
// PURPOSE
//  Retirement-side rename state, directly downstream of the ROB.
//  - Consumes each dequeued ROB entry and updates the retirement RAT (RRF, arch -> phys).
//  - Returns the superseded physical register to a circular free list.
//  - The free list feeds rename/dispatch with new destination tags.
//  - On a branch flush, rolls the free list back to its committed point and presents the RRF
//    so the front-end RAT can restore from it.
// PARAMETERS
//  NUM_ARCH   32                      architectural registers (x0..x31)
//  NUM_PHYS   64                      physical registers; the free list holds NUM_PHYS-NUM_ARCH entries
//  PHYS_W     $clog2(NUM_PHYS)        physical tag width (6)
//  FL_DEPTH   NUM_PHYS-NUM_ARCH       free-list capacity (32)
// PORTS
//  clk            in   1               clock
//  rst            in   1               reset; asynchronous, active-high
//  retire_valid   in   1               ROB dequeue_valid
//  retire_rd      in   5               rob_out.rvfi.monitor_rd_addr
//  retire_pd      in   PHYS_W          rob_out.pd
//  retire_we      in   1               rob_out.rvfi.monitor_regf_we
//  fl_dequeue     in   1               rename consumes fl_pd this cycle
//  fl_pd          out  PHYS_W          free tag at the head (show-ahead)
//  fl_empty       out  1               no free tag available
//  fl_count       out  $clog2(FL_DEPTH)+1   number of free tags
//  flush          in   1               global_branch_signal from the ROB
//  rrf_map        out  NUM_ARCH*PHYS_W  registered RRF; entry i at [i*PHYS_W +: PHYS_W]
//  restore_valid  out  1               one-cycle pulse: rrf_map and free list are post-flush consistent
// BEHAVIOUR
//  Reset (async, rst=1):
//   - rrf[i]=i; free-list slot j holds NUM_ARCH+j.
//   - head=0; commit_head=0; tail={1'b1,0} (full).
//   - Outputs: fl_pd=32, fl_empty=0, fl_count=32, restore_valid=0.
//   - Asserting rst mid-operation discards all in-flight state.
//  Retire (retire_valid && retire_we && retire_rd!=0):
//   - old = rrf[rd]; rrf[rd] <= retire_pd.
//   - Push old at tail; tail+1.
//   - commit_head+1: the retiring pd was popped in order.
//   - Retire with rd==0 or we==0: no state change.
//  Pop (fl_dequeue && !fl_empty && !flush): head+1.
//   - fl_pd is combinational from mem[head]; the new head is visible the next cycle.
//   - Pop while empty: ignored, no underflow.
//  Pointers carry an extra wrap bit.
//   - empty = (head==tail).
//   - count = tail-head, in 0..FL_DEPTH.
//   - A push never occurs at count==FL_DEPTH: the arch-mapping invariant guarantees it.
//     Assert it in simulation.
//  Same-cycle pop+push: both apply.
//   - Pop at count==0 is ignored even when a push lands the same cycle; no bypass.
//  Flush:
//   - head <= commit_head, including any same-cycle retire increment.
//   - A pop in the same cycle is dropped; a same-cycle retire is applied fully.
//   - restore_valid=1 the following cycle; rename copies rrf_map into the RAT on that pulse.
//   - fl_dequeue during restore_valid is honoured.
//   - Back-to-back flushes: each one re-pulses restore_valid.
//  Latency: retire -> rrf_map / fl_count visible 1 cycle later.
// STRUCTURE
//  Package rv32i_types:
//   - Add NUM_ARCH_REGS, NUM_PHYS_REGS, PHYS_W.
//   - Add typedef phys_tag_t = logic [PHYS_W-1:0].
//  Sub-module phys_free_list:
//   - Circular FIFO with head, tail, commit_head and a flush rollback.
//   - Async-reset init as above.
//  retire_map holds the RRF array, the retire decode and the restore_valid flop.
// TESTING
//  1. Reset release -> fl_pd=32, fl_count=32, rrf_map[x5]=5, fl_empty=0.
//  2. Pop 32x consecutively -> fl_pd walks 32..63; fl_empty=1 after the 32nd.
//     A 33rd pop leaves head unchanged.
//  3. Pop p32 then retire {rd=5, pd=32, we=1} -> next cycle rrf[5]=32, fl_count=32,
//     tail entry=5 (popped when the list wraps).
//  4. Retire {rd=0, pd=40, we=1} and {rd=7, we=0} -> rrf_map and fl_count unchanged.
//  5. Pop 3 (p32..p34); retire p32 to rd=1; flush -> next cycle head=commit_head=1,
//     fl_pd=33, fl_count=32, restore_valid=1 for one cycle.
//  6. flush + fl_dequeue + retire (rd=2) in one cycle -> pop dropped, rrf[2] updated,
//     head=commit_head+1; async rst mid-burst -> the reset values of test 1.

Source files
------------

// File: rtl/retire_map_pkg.sv
// Shared types and sizing for the retirement-side rename state.
// Holds register-file dimensions, the physical tag type, the free-list
// pointer and count types, the retire request struct, and a helper that
// gives the reset contents of each free-list slot.
package retire_map_pkg;

    localparam int NUM_ARCH_REGS = 32;
    localparam int NUM_PHYS_REGS = 64;
    localparam int PHYS_W        = $clog2(NUM_PHYS_REGS);
    localparam int ARCH_W        = $clog2(NUM_ARCH_REGS);

    // The free list only ever holds tags that are not currently mapped
    // in the RRF, so its capacity is the surplus of physical registers.
    localparam int FL_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int FL_IDX_W = $clog2(FL_DEPTH);
    localparam int FL_PTR_W = FL_IDX_W + 1;          // extra wrap bit
    localparam int FL_CNT_W = $clog2(FL_DEPTH) + 1;  // holds 0..FL_DEPTH

    typedef logic [PHYS_W-1:0]   phys_tag_t;
    typedef logic [ARCH_W-1:0]   arch_reg_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;
    typedef logic [FL_CNT_W-1:0] fl_cnt_t;

    typedef struct packed {
        logic      valid;
        logic      we;
        arch_reg_t rd;
        phys_tag_t pd;
    } retire_req_t;

    // After reset, slot j holds the first unmapped tag past the identity map.
    function automatic phys_tag_t init_free_tag(input int slot);
        return phys_tag_t'(NUM_ARCH_REGS + slot);
    endfunction

endpackage

// File: rtl/retire_map_if.sv
// Bus between the ROB/rename side (master) and retire_map (slave).
// master drives : retire_valid, retire_rd, retire_pd, retire_we,
//                 fl_dequeue, flush
// slave drives  : fl_pd, fl_empty, fl_count, rrf_map, restore_valid
interface retire_map_if;
    import retire_map_pkg::*;

    logic                             retire_valid;
    arch_reg_t                        retire_rd;
    phys_tag_t                        retire_pd;
    logic                             retire_we;
    logic                             fl_dequeue;
    phys_tag_t                        fl_pd;
    logic                             fl_empty;
    fl_cnt_t                          fl_count;
    logic                             flush;
    logic [NUM_ARCH_REGS*PHYS_W-1:0]  rrf_map;
    logic                             restore_valid;

    modport master (
        output retire_valid, retire_rd, retire_pd, retire_we,
        output fl_dequeue, flush,
        input  fl_pd, fl_empty, fl_count, rrf_map, restore_valid
    );

    modport slave (
        input  retire_valid, retire_rd, retire_pd, retire_we,
        input  fl_dequeue, flush,
        output fl_pd, fl_empty, fl_count, rrf_map, restore_valid
    );

endinterface

// File: rtl/retire_map_free_list.sv
// phys_free_list: circular FIFO of free physical tags.
//  - head   : next tag handed to rename (speculative pop point)
//  - tail   : where superseded tags are returned at retire
//  - commit_head : head as seen by retirement; a flush rolls head back here
// Ports:
//  clk, rst     clock, async active-high reset
//  i_push       return i_push_tag at tail
//  i_push_tag   superseded tag
//  i_commit     oldest popped tag has retired
//  i_pop        rename consumes o_head_tag
//  i_flush      roll head back to the committed point
//  o_head_tag   show-ahead tag at head
//  o_empty      no free tag
//  o_count      number of free tags
module phys_free_list
    import retire_map_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  phys_tag_t i_push_tag,
    input  logic      i_commit,
    input  logic      i_pop,
    input  logic      i_flush,
    output phys_tag_t o_head_tag,
    output logic      o_empty,
    output fl_cnt_t   o_count
);

    localparam fl_cnt_t FL_FULL = fl_cnt_t'(FL_DEPTH);

    phys_tag_t r_mem [FL_DEPTH];
    fl_ptr_t   r_head;
    fl_ptr_t   r_tail;
    fl_ptr_t   r_commit_head;

    logic      w_pop;
    fl_ptr_t   w_commit_next;
    fl_cnt_t   w_count;

    // Wrap bit makes full and empty distinguishable with equal indices.
    assign o_empty    = (r_head == r_tail);
    assign w_count    = fl_cnt_t'(r_tail - r_head);
    assign o_count    = w_count;
    assign o_head_tag = r_mem[r_head[FL_IDX_W-1:0]];

    // A flush drops a same-cycle pop; a pop on an empty list is ignored
    // even when a push lands the same cycle (no bypass).
    assign w_pop = i_pop && !o_empty && !i_flush;

    // Rollback target includes a retire landing in the flush cycle.
    assign w_commit_next = r_commit_head + fl_ptr_t'(i_commit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < FL_DEPTH; j++) begin
                r_mem[j] <= init_free_tag(j);
            end
            r_head        <= '0;
            r_commit_head <= '0;
            r_tail        <= {1'b1, {FL_IDX_W{1'b0}}};
        end else begin
            if (i_push) begin
                r_mem[r_tail[FL_IDX_W-1:0]] <= i_push_tag;
                r_tail                      <= r_tail + fl_ptr_t'(1);
            end
            r_commit_head <= w_commit_next;
            if (i_flush) begin
                r_head <= w_commit_next;
            end else if (w_pop) begin
                r_head <= r_head + fl_ptr_t'(1);
            end
        end
    end

    // Every retired tag was popped earlier, so the list can never be full
    // when a superseded tag comes back.
    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (rst) i_push |-> (w_count != FL_FULL)
    );

endmodule

// File: rtl/retire_map.sv
// retire_map: retirement RAT (RRF) plus the physical free list.
//  - A retire with we=1 and rd!=0 maps rd to the retiring tag and hands
//    the superseded tag back to the free list.
//  - A flush rolls the free list back to its committed point; the cycle
//    after, restore_valid pulses so rename can copy rrf_map into its RAT.
// Ports:
//  clk, rst  clock, async active-high reset
//  bus       retire_map_if.slave (retire request, free-list handshake,
//            flush, rrf_map, restore_valid)
module retire_map
    import retire_map_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    retire_map_if.slave  bus
);

    retire_req_t w_req;
    logic        w_retire;
    phys_tag_t   w_old_pd;
    logic [NUM_ARCH_REGS*PHYS_W-1:0] w_rrf_map;

    phys_tag_t   r_rrf [NUM_ARCH_REGS];
    logic        r_restore_valid;

    assign w_req = '{
        valid: bus.retire_valid,
        we:    bus.retire_we,
        rd:    bus.retire_rd,
        pd:    bus.retire_pd
    };

    // x0 is never renamed, so retiring into it is a no-op.
    assign w_retire = w_req.valid && w_req.we && (w_req.rd != '0);
    assign w_old_pd = r_rrf[w_req.rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                r_rrf[i] <= phys_tag_t'(i);
            end
        end else if (w_retire) begin
            r_rrf[w_req.rd] <= w_req.pd;
        end
    end

    // Each flush re-pulses, so back-to-back flushes keep it high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_restore_valid <= 1'b0;
        end else begin
            r_restore_valid <= bus.flush;
        end
    end

    always_comb begin
        w_rrf_map = '0;
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            w_rrf_map[i*PHYS_W +: PHYS_W] = r_rrf[i];
        end
    end

    assign bus.rrf_map       = w_rrf_map;
    assign bus.restore_valid = r_restore_valid;

    // Retiring instructions consumed their tags in order, so each
    // effective retire also advances the committed head.
    phys_free_list u_free_list (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_retire),
        .i_push_tag (w_old_pd),
        .i_commit   (w_retire),
        .i_pop      (bus.fl_dequeue),
        .i_flush    (bus.flush),
        .o_head_tag (bus.fl_pd),
        .o_empty    (bus.fl_empty),
        .o_count    (bus.fl_count)
    );

endmodule

// File: tb/tb_retire_map.sv
module tb_retire_map;
    import retire_map_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    retire_map_if bus ();
    retire_map dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    // Reference: free tags in hand-out order, tags handed out but not yet
    // retired (oldest first), and the architectural map.
    int m_fl[$];
    int m_inflight[$];
    int m_rrf[NUM_ARCH_REGS];
    bit m_restore;

    function automatic int rrf_at(input int i);
        return int'(bus.rrf_map[i*PHYS_W +: PHYS_W]);
    endfunction

    task automatic model_reset();
        m_fl.delete();
        m_inflight.delete();
        for (int j = 0; j < FL_DEPTH; j++) m_fl.push_back(NUM_ARCH_REGS + j);
        for (int i = 0; i < NUM_ARCH_REGS; i++) m_rrf[i] = i;
        m_restore = 0;
    endtask

    task automatic idle();
        bus.retire_valid = 0;
        bus.retire_rd    = '0;
        bus.retire_pd    = '0;
        bus.retire_we    = 0;
        bus.fl_dequeue   = 0;
        bus.flush        = 0;
    endtask

    task automatic set_retire(input int rd, input int pd, input bit we);
        bus.retire_valid = 1;
        bus.retire_rd    = arch_reg_t'(rd);
        bus.retire_pd    = phys_tag_t'(pd);
        bus.retire_we    = we;
    endtask

    // One clock with the currently driven inputs; model follows the rules.
    task automatic tick();
        bit pop_ok;
        int rd;
        @(posedge clk);
        #1;
        pop_ok = bus.fl_dequeue && !bus.flush && (m_fl.size() > 0);
        if (pop_ok) m_inflight.push_back(m_fl.pop_front());
        rd = int'(bus.retire_rd);
        if (bus.retire_valid && bus.retire_we && rd != 0) begin
            m_fl.push_back(m_rrf[rd]);
            m_rrf[rd] = int'(bus.retire_pd);
            if (m_inflight.size() > 0) void'(m_inflight.pop_front());
        end
        if (bus.flush) begin
            m_fl = {m_inflight, m_fl};
            m_inflight.delete();
        end
        m_restore = bus.flush;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic drive_random();
        bus.fl_dequeue = 1'($urandom_range(0, 1));
        bus.flush      = ($urandom_range(0, 15) == 0);
        if (m_inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
            set_retire($urandom_range(0, NUM_ARCH_REGS-1), m_inflight[0],
                       ($urandom_range(0, 7) != 0));
        end else begin
            set_retire($urandom_range(0, NUM_ARCH_REGS-1), $urandom_range(0, 63), 0);
            bus.retire_valid = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.fl_pd !== 6'd32) begin failures++; $display("FAIL reset_fl_pd got=%0d exp=32", bus.fl_pd); end
        checks++; if (bus.fl_count !== 6'd32) begin failures++; $display("FAIL reset_fl_count got=%0d exp=32", bus.fl_count); end
        checks++; if (bus.fl_empty !== 1'b0) begin failures++; $display("FAIL reset_fl_empty got=%0b exp=0", bus.fl_empty); end
        checks++; if (bus.restore_valid !== 1'b0) begin failures++; $display("FAIL reset_restore got=%0b exp=0", bus.restore_valid); end
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            checks++;
            if (rrf_at(i) !== i) begin failures++; $display("FAIL reset_rrf[%0d] got=%0d exp=%0d", i, rrf_at(i), i); end
        end
    endtask

    task automatic test_pop_all();
        do_reset();
        bus.fl_dequeue = 1;
        for (int i = 0; i < FL_DEPTH; i++) begin
            checks++;
            if (bus.fl_pd !== phys_tag_t'(32 + i)) begin failures++; $display("FAIL pop_walk[%0d] got=%0d exp=%0d", i, bus.fl_pd, 32 + i); end
            tick();
        end
        checks++; if (bus.fl_empty !== 1'b1) begin failures++; $display("FAIL pop_all_empty got=%0b exp=1", bus.fl_empty); end
        checks++; if (bus.fl_count !== 6'd0) begin failures++; $display("FAIL pop_all_count got=%0d exp=0", bus.fl_count); end
        tick();  // pop while empty
        checks++; if (bus.fl_count !== 6'd0) begin failures++; $display("FAIL pop_underflow_count got=%0d exp=0", bus.fl_count); end
        idle();
        set_retire(3, 32, 1);
        tick();
        idle();
        checks++; if (bus.fl_count !== 6'd1) begin failures++; $display("FAIL pop_underflow_push_count got=%0d exp=1", bus.fl_count); end
        checks++; if (bus.fl_pd !== 6'd3) begin failures++; $display("FAIL pop_underflow_head got=%0d exp=3", bus.fl_pd); end
    endtask

    task automatic test_retire_basic();
        do_reset();
        bus.fl_dequeue = 1;
        tick();
        idle();
        set_retire(5, 32, 1);
        tick();
        idle();
        checks++; if (rrf_at(5) !== 32) begin failures++; $display("FAIL retire_rrf5 got=%0d exp=32", rrf_at(5)); end
        checks++; if (bus.fl_count !== 6'd32) begin failures++; $display("FAIL retire_count got=%0d exp=32", bus.fl_count); end
        bus.fl_dequeue = 1;
        repeat (31) tick();
        idle();
        checks++; if (bus.fl_pd !== 6'd5) begin failures++; $display("FAIL retire_tail_entry got=%0d exp=5", bus.fl_pd); end
    endtask

    task automatic test_retire_noop();
        do_reset();
        set_retire(0, 40, 1);
        tick();
        set_retire(7, 41, 0);
        tick();
        idle();
        checks++; if (bus.fl_count !== 6'd32) begin failures++; $display("FAIL noop_count got=%0d exp=32", bus.fl_count); end
        checks++; if (bus.fl_pd !== 6'd32) begin failures++; $display("FAIL noop_fl_pd got=%0d exp=32", bus.fl_pd); end
        checks++; if (rrf_at(0) !== 0) begin failures++; $display("FAIL noop_rrf0 got=%0d exp=0", rrf_at(0)); end
        checks++; if (rrf_at(7) !== 7) begin failures++; $display("FAIL noop_rrf7 got=%0d exp=7", rrf_at(7)); end
    endtask

    task automatic test_flush();
        do_reset();
        bus.fl_dequeue = 1;
        repeat (3) tick();
        idle();
        set_retire(1, 32, 1);
        tick();
        idle();
        bus.flush = 1;
        tick();
        idle();
        checks++; if (bus.fl_pd !== 6'd33) begin failures++; $display("FAIL flush_fl_pd got=%0d exp=33", bus.fl_pd); end
        checks++; if (bus.fl_count !== 6'd32) begin failures++; $display("FAIL flush_count got=%0d exp=32", bus.fl_count); end
        checks++; if (bus.restore_valid !== 1'b1) begin failures++; $display("FAIL flush_restore got=%0b exp=1", bus.restore_valid); end
        checks++; if (rrf_at(1) !== 32) begin failures++; $display("FAIL flush_rrf1 got=%0d exp=32", rrf_at(1)); end
        tick();
        checks++; if (bus.restore_valid !== 1'b0) begin failures++; $display("FAIL flush_restore_pulse got=%0b exp=0", bus.restore_valid); end
    endtask

    task automatic test_flush_combo();
        do_reset();
        bus.fl_dequeue = 1;
        repeat (2) tick();
        bus.flush = 1;
        set_retire(2, 32, 1);
        tick();
        idle();
        checks++; if (rrf_at(2) !== 32) begin failures++; $display("FAIL combo_rrf2 got=%0d exp=32", rrf_at(2)); end
        checks++; if (bus.fl_pd !== 6'd33) begin failures++; $display("FAIL combo_fl_pd got=%0d exp=33", bus.fl_pd); end
        checks++; if (bus.fl_count !== 6'd32) begin failures++; $display("FAIL combo_count got=%0d exp=32", bus.fl_count); end
        checks++; if (bus.restore_valid !== 1'b1) begin failures++; $display("FAIL combo_restore got=%0b exp=1", bus.restore_valid); end
        // back-to-back flushes, then a pop during the restore pulse
        bus.flush = 1;
        tick();
        checks++; if (bus.restore_valid !== 1'b1) begin failures++; $display("FAIL b2b_restore1 got=%0b exp=1", bus.restore_valid); end
        tick();
        bus.flush = 0;
        bus.fl_dequeue = 1;
        checks++; if (bus.restore_valid !== 1'b1) begin failures++; $display("FAIL b2b_restore2 got=%0b exp=1", bus.restore_valid); end
        tick();
        idle();
        checks++; if (bus.restore_valid !== 1'b0) begin failures++; $display("FAIL b2b_restore_end got=%0b exp=0", bus.restore_valid); end
        checks++; if (bus.fl_pd !== 6'd34) begin failures++; $display("FAIL restore_pop_pd got=%0d exp=34", bus.fl_pd); end
        checks++; if (bus.fl_count !== 6'd31) begin failures++; $display("FAIL restore_pop_count got=%0d exp=31", bus.fl_count); end
    endtask

    task automatic test_random(input int cycles);
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            drive_random();
            tick();
            checks++;
            if (bus.fl_count !== phys_tag_t'(m_fl.size())) begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, bus.fl_count, m_fl.size()); end
            checks++;
            if (bus.fl_empty !== (m_fl.size() == 0)) begin failures++; $display("FAIL rnd_empty c=%0d got=%0b exp=%0b", c, bus.fl_empty, m_fl.size() == 0); end
            if (m_fl.size() > 0) begin
                checks++;
                if (int'(bus.fl_pd) !== m_fl[0]) begin failures++; $display("FAIL rnd_fl_pd c=%0d got=%0d exp=%0d", c, bus.fl_pd, m_fl[0]); end
            end
            checks++;
            if (bus.restore_valid !== m_restore) begin failures++; $display("FAIL rnd_restore c=%0d got=%0b exp=%0b", c, bus.restore_valid, m_restore); end
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                checks++;
                if (rrf_at(i) !== m_rrf[i]) begin failures++; $display("FAIL rnd_rrf[%0d] c=%0d got=%0d exp=%0d", i, c, rrf_at(i), m_rrf[i]); end
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        test_random(40);
        drive_random();
        @(posedge clk);
        #2;
        rst = 1;  // mid-cycle, no clock edge
        #1;
        checks++; if (bus.fl_count !== 6'd32) begin failures++; $display("FAIL async_rst_count got=%0d exp=32", bus.fl_count); end
        checks++; if (bus.fl_pd !== 6'd32) begin failures++; $display("FAIL async_rst_fl_pd got=%0d exp=32", bus.fl_pd); end
        idle();
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        checks++; if (bus.fl_empty !== 1'b0) begin failures++; $display("FAIL async_rst_empty got=%0b exp=0", bus.fl_empty); end
        checks++; if (bus.restore_valid !== 1'b0) begin failures++; $display("FAIL async_rst_restore got=%0b exp=0", bus.restore_valid); end
        checks++; if (rrf_at(5) !== 5) begin failures++; $display("FAIL async_rst_rrf5 got=%0d exp=5", rrf_at(5)); end
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            checks++;
            if (rrf_at(i) !== i) begin failures++; $display("FAIL async_rst_rrf[%0d] got=%0d exp=%0d", i, rrf_at(i), i); end
        end
    endtask

    initial begin
        idle();
        rst = 1;
        #12;
        test_reset();
        test_pop_all();
        test_retire_basic();
        test_retire_noop();
        test_flush();
        test_flush_combo();
        test_random(2000);
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
